// File: rtl/cache_pkg.sv
// Shared definitions for the ACE cache datapath: line geometry, coherence
// state encoding, AR/AW/AC snoop codes, CR_RESP bit positions and the fixed
// AXI address-channel fields.
package cache_pkg;

    // Line geometry: 16 single-word lines, word-aligned.
    localparam int NUM_LINES = 16;
    localparam int INDEX_W   = 4;
    localparam int OFFSET_W  = 2;
    localparam int ID_W      = 4;

    // Coherence state of a line.
    typedef enum logic [2:0] {
        ST_UNIQUE_CLEAN = 3'b000,
        ST_UNIQUE_DIRTY = 3'b001,
        ST_SHARED_DIRTY = 3'b010,
        ST_INVALID      = 3'b011,
        ST_SHARED_CLEAN = 3'b100
    } line_state_e;

    // Outgoing read snoop codes.
    localparam logic [3:0] AR_SNOOP_READ_NO_SNOOP = 4'b0000;
    localparam logic [3:0] AR_SNOOP_READ_SHARED   = 4'b0001;
    localparam logic [3:0] AR_SNOOP_MAKE_UNIQUE   = 4'b1100;

    // Outgoing write snoop codes.
    localparam logic [2:0] AW_SNOOP_WRITE_NO_SNOOP = 3'b000;
    localparam logic [2:0] AW_SNOOP_WRITE_CLEAN    = 3'b010;

    // Incoming snoop codes.
    localparam logic [3:0] AC_READ_SHARED   = 4'b0001;
    localparam logic [3:0] AC_CLEAN_INVALID = 4'b1001;
    localparam logic [3:0] AC_MAKE_INVALID  = 4'b1101;

    // CR_RESP bit positions.
    localparam int CR_DATA_TRANSFER = 0;
    localparam int CR_ERROR         = 1;
    localparam int CR_PASS_DIRTY    = 2;
    localparam int CR_IS_SHARED     = 3;
    localparam int CR_WAS_UNIQUE    = 4;

    // Fixed AXI fields shared by the AR and AW channels.
    localparam logic [ID_W-1:0] AXI_ID     = 4'd0;
    localparam logic [2:0]      AXI_SIZE   = 3'b010;
    localparam logic [1:0]      AXI_BURST  = 2'b01;
    localparam logic [7:0]      AXI_LEN    = 8'd0;
    localparam logic [2:0]      AXI_PROT   = 3'b000;
    localparam logic [3:0]      AXI_CACHE  = 4'b0011;
    localparam logic [1:0]      AXI_BAR    = 2'b00;
    localparam logic [1:0]      AXI_DOMAIN = 2'b01;

    // A line this cache owns exclusively.
    function automatic logic is_unique(input logic [2:0] st);
        return (st == ST_UNIQUE_CLEAN) || (st == ST_UNIQUE_DIRTY);
    endfunction

    // A line whose data differs from memory.
    function automatic logic is_dirty(input logic [2:0] st);
        return (st == ST_UNIQUE_DIRTY) || (st == ST_SHARED_DIRTY);
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// Tag, data and coherence-state storage for the direct-mapped cache.
// CPU port: combinational read, data/tag write and state write.
// Snoop port: combinational read and a state write that wins over a CPU
// state write to the same line in the same cycle.
module cache_line_array
    import cache_pkg::*;
#(
    parameter int TAG_W   = 26,
    parameter int DATA_W  = 32,
    parameter int STATE_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] cpu_index,
    input  logic               data_we,
    input  logic [TAG_W-1:0]   wtag,
    input  logic [DATA_W-1:0]  wdata,
    input  logic               state_we,
    input  logic [STATE_W-1:0] wstate,
    output logic [TAG_W-1:0]   cpu_tag,
    output logic [DATA_W-1:0]  cpu_data,
    output logic [STATE_W-1:0] cpu_state,
    input  logic [INDEX_W-1:0] snp_index,
    input  logic               snp_state_we,
    input  logic [STATE_W-1:0] snp_wstate,
    output logic [TAG_W-1:0]   snp_tag,
    output logic [DATA_W-1:0]  snp_data,
    output logic [STATE_W-1:0] snp_state
);

    logic [TAG_W-1:0]   tags   [NUM_LINES];
    logic [DATA_W-1:0]  datas  [NUM_LINES];
    logic [STATE_W-1:0] states [NUM_LINES];
    logic               snoop_owns_line;

    assign cpu_tag   = tags[cpu_index];
    assign cpu_data  = datas[cpu_index];
    assign cpu_state = states[cpu_index];
    assign snp_tag   = tags[snp_index];
    assign snp_data  = datas[snp_index];
    assign snp_state = states[snp_index];

    // A snoop state write to the CPU-indexed line masks the CPU state write.
    always_comb begin
        snoop_owns_line = snp_state_we && (snp_index == cpu_index);
    end

    // Line storage: reset to Invalid/zero, then CPU and snoop writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                tags[i]   <= '0;
                datas[i]  <= '0;
                states[i] <= STATE_W'(ST_INVALID);
            end
        end else begin
            if (data_we) begin
                tags[cpu_index]  <= wtag;
                datas[cpu_index] <= wdata;
            end
            if (state_we && !snoop_owns_line) begin
                states[cpu_index] <= wstate;
            end
            if (snp_state_we) begin
                states[snp_index] <= snp_wstate;
            end
        end
    end

endmodule

// File: rtl/ace_cache_datapath.sv
// Direct-mapped single-word-line data cache datapath for an ACE CPU port.
// Performs CPU and snoop lookups, drives AR/AW/W/CR/CD payloads and decodes
// R/B responses. Sequencing comes from external controllers via strobes.
// Optional feature macro: CACHE_DP_SNOOP_EN enables snoop lookup, snoop
// state changes and the CR/CD outputs; without it they are tied to 0.
module ace_cache_datapath
    import cache_pkg::*;
#(
    parameter int WIDTH_A     = 32,
    parameter int WIDTH_D     = 32,
    parameter int WIDTH_STATE = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH_A-1:0]     cpu_addr,
    input  logic [WIDTH_D-1:0]     cpu_wdata,
    output logic [WIDTH_D-1:0]     cpu_rdata,
    input  logic                   write_from_cpu,
    input  logic                   write_from_interconnect,
    input  logic [WIDTH_STATE-1:0] new_state,
    input  logic                   mux_en,
    output logic                   cache_hit,
    output logic                   cache_miss,
    output logic [WIDTH_STATE-1:0] line_state,
    input  logic                   read_shared,
    input  logic                   make_unique,
    input  logic                   write_clean,
    input  logic                   read_resp_en,
    input  logic                   ac_enable,
    input  logic [WIDTH_A-1:0]     AC_ADDR,
    input  logic [3:0]             AC_SNOOP,
    input  logic [2:0]             AC_PROT,
    input  logic [WIDTH_D-1:0]     RDATA,
    input  logic [3:0]             RRESP,
    input  logic [ID_W-1:0]        R_ID,
    input  logic                   R_LAST,
    input  logic [1:0]             BRESP,
    input  logic [ID_W-1:0]        B_ID,
    output logic                   R_okay,
    output logic                   B_okay,
    output logic                   invalid,
    output logic                   snoop_miss,
    output logic                   response,
    output logic                   response_data,
    output logic [4:0]             CR_RESP,
    output logic [WIDTH_D-1:0]     CD_DATA,
    output logic                   CD_LAST,
    output logic [WIDTH_A-1:0]     AR_ADDR,
    output logic [ID_W-1:0]        AR_ID,
    output logic [2:0]             AR_SIZE,
    output logic [1:0]             AR_BURST,
    output logic [7:0]             AR_LEN,
    output logic [2:0]             AR_PROT,
    output logic [3:0]             AR_CACHE,
    output logic [1:0]             AR_BAR,
    output logic [1:0]             AR_DOMAIN,
    output logic [3:0]             AR_SNOOP,
    output logic [WIDTH_A-1:0]     AW_ADDR,
    output logic [ID_W-1:0]        AW_ID,
    output logic [2:0]             AW_SIZE,
    output logic [1:0]             AW_BURST,
    output logic [7:0]             AW_LEN,
    output logic [2:0]             AW_PROT,
    output logic [3:0]             AW_CACHE,
    output logic [1:0]             AW_BAR,
    output logic [1:0]             AW_DOMAIN,
    output logic [2:0]             AW_SNOOP,
    output logic                   W_STRB,
    output logic                   W_LAST,
    output logic [WIDTH_D-1:0]     W_DATA
);

    localparam int TAG_W = WIDTH_A - OFFSET_W - INDEX_W;
    localparam logic [WIDTH_STATE-1:0] STATE_INVALID = WIDTH_STATE'(ST_INVALID);

    logic [INDEX_W-1:0]     cpu_index;
    logic [TAG_W-1:0]       cpu_tag_in;
    logic [TAG_W-1:0]       line_tag;
    logic [WIDTH_D-1:0]     line_data;
    logic [WIDTH_STATE-1:0] line_st;
    logic                   data_we;
    logic [WIDTH_D-1:0]     fill_data;
    logic [INDEX_W-1:0]     snp_index;
    logic                   snp_state_we;
    logic [WIDTH_STATE-1:0] snp_wstate;
    logic [TAG_W-1:0]       snp_tag;
    logic [WIDTH_D-1:0]     snp_data;
    logic [WIDTH_STATE-1:0] snp_state;
    logic                   unused_inputs;

    assign cpu_index  = cpu_addr[OFFSET_W +: INDEX_W];
    assign cpu_tag_in = cpu_addr[WIDTH_A-1 -: TAG_W];
    assign data_we    = write_from_cpu || write_from_interconnect;

    // CPU write data has priority over the interconnect fill.
    always_comb begin
        if (write_from_cpu) begin
            fill_data = cpu_wdata;
        end else begin
            fill_data = RDATA;
        end
    end

    cache_line_array #(
        .TAG_W   (TAG_W),
        .DATA_W  (WIDTH_D),
        .STATE_W (WIDTH_STATE)
    ) u_lines (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_index    (cpu_index),
        .data_we      (data_we),
        .wtag         (cpu_tag_in),
        .wdata        (fill_data),
        .state_we     (mux_en),
        .wstate       (new_state),
        .cpu_tag      (line_tag),
        .cpu_data     (line_data),
        .cpu_state    (line_st),
        .snp_index    (snp_index),
        .snp_state_we (snp_state_we),
        .snp_wstate   (snp_wstate),
        .snp_tag      (snp_tag),
        .snp_data     (snp_data),
        .snp_state    (snp_state)
    );

    // CPU lookup result for the indexed line.
    always_comb begin
        cache_hit  = (line_tag == cpu_tag_in) && (line_st != STATE_INVALID);
        cache_miss = !cache_hit;
        line_state = line_st;
        cpu_rdata  = line_data;
    end

    // Read snoop code: MakeUnique outranks ReadShared.
    always_comb begin
        if (make_unique) begin
            AR_SNOOP = AR_SNOOP_MAKE_UNIQUE;
        end else if (read_shared) begin
            AR_SNOOP = AR_SNOOP_READ_SHARED;
        end else begin
            AR_SNOOP = AR_SNOOP_READ_NO_SNOOP;
        end
    end

    // Write snoop code for write-backs.
    always_comb begin
        if (write_clean) begin
            AW_SNOOP = AW_SNOOP_WRITE_CLEAN;
        end else begin
            AW_SNOOP = AW_SNOOP_WRITE_NO_SNOOP;
        end
    end

    assign AR_ADDR   = {cpu_addr[WIDTH_A-1:OFFSET_W], 2'b00};
    assign AR_ID     = AXI_ID;
    assign AR_SIZE   = AXI_SIZE;
    assign AR_BURST  = AXI_BURST;
    assign AR_LEN    = AXI_LEN;
    assign AR_PROT   = AXI_PROT;
    assign AR_CACHE  = AXI_CACHE;
    assign AR_BAR    = AXI_BAR;
    assign AR_DOMAIN = AXI_DOMAIN;

    // Write-back address is rebuilt from the stored tag, not the CPU tag.
    assign AW_ADDR   = {line_tag, cpu_index, 2'b00};
    assign AW_ID     = AXI_ID;
    assign AW_SIZE   = AXI_SIZE;
    assign AW_BURST  = AXI_BURST;
    assign AW_LEN    = AXI_LEN;
    assign AW_PROT   = AXI_PROT;
    assign AW_CACHE  = AXI_CACHE;
    assign AW_BAR    = AXI_BAR;
    assign AW_DOMAIN = AXI_DOMAIN;
    assign W_DATA    = line_data;
    assign W_STRB    = 1'b1;
    assign W_LAST    = 1'b1;

    // R status is captured only when the controller says a response is valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            R_okay <= 1'b0;
        end else if (read_resp_en) begin
            R_okay <= (RRESP[1:0] == 2'b00);
        end
    end

    // B status is sampled every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            B_okay <= 1'b0;
        end else begin
            B_okay <= (BRESP == 2'b00);
        end
    end

`ifdef CACHE_DP_SNOOP_EN
    logic       snp_hit;
    logic       miss_next;
    logic       inv_next;
    logic       data_next;
    logic [4:0] cr_next;
    logic       unused_snoop;

    assign snp_index    = AC_ADDR[OFFSET_W +: INDEX_W];
    assign unused_snoop = ^{AC_PROT, AC_ADDR[OFFSET_W-1:0]};

    // Snoop lookup and the response/state change it implies.
    always_comb begin
        snp_hit      = (snp_tag == AC_ADDR[WIDTH_A-1 -: TAG_W]) && (snp_state != STATE_INVALID);
        miss_next    = !snp_hit;
        inv_next     = 1'b0;
        data_next    = 1'b0;
        cr_next      = 5'b00000;
        snp_state_we = 1'b0;
        snp_wstate   = STATE_INVALID;
        if (snp_hit) begin
            cr_next[CR_WAS_UNIQUE] = is_unique(3'(snp_state));
            case (AC_SNOOP)
                AC_READ_SHARED: begin
                    cr_next[CR_IS_SHARED]     = 1'b1;
                    cr_next[CR_PASS_DIRTY]    = (snp_state == WIDTH_STATE'(ST_UNIQUE_DIRTY));
                    cr_next[CR_DATA_TRANSFER] = 1'b1;
                    data_next                 = 1'b1;
                    snp_state_we              = ac_enable;
                    // A SharedDirty owner keeps write-back responsibility.
                    if (snp_state == WIDTH_STATE'(ST_SHARED_DIRTY)) begin
                        snp_wstate = WIDTH_STATE'(ST_SHARED_DIRTY);
                    end else begin
                        snp_wstate = WIDTH_STATE'(ST_SHARED_CLEAN);
                    end
                end
                AC_CLEAN_INVALID, AC_MAKE_INVALID: begin
                    inv_next     = 1'b1;
                    snp_state_we = ac_enable;
                    snp_wstate   = STATE_INVALID;
                    // Only CleanInvalid hands dirty data back.
                    if ((AC_SNOOP == AC_CLEAN_INVALID) && is_dirty(3'(snp_state))) begin
                        cr_next[CR_PASS_DIRTY]    = 1'b1;
                        cr_next[CR_DATA_TRANSFER] = 1'b1;
                        data_next                 = 1'b1;
                    end else begin
                        data_next = 1'b0;
                    end
                end
                default: begin
                    cr_next[CR_IS_SHARED]     = 1'b1;
                    cr_next[CR_PASS_DIRTY]    = (snp_state == WIDTH_STATE'(ST_UNIQUE_DIRTY));
                    cr_next[CR_DATA_TRANSFER] = 1'b1;
                    data_next                 = 1'b1;
                end
            endcase
        end else begin
            cr_next = 5'b00000;
        end
    end

    // Snoop response registers: valid for exactly the cycle after ac_enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snoop_miss    <= 1'b0;
            invalid       <= 1'b0;
            response      <= 1'b0;
            response_data <= 1'b0;
            CR_RESP       <= 5'b00000;
            CD_DATA       <= '0;
            CD_LAST       <= 1'b0;
        end else if (ac_enable) begin
            snoop_miss    <= miss_next;
            invalid       <= inv_next;
            response      <= 1'b1;
            response_data <= data_next;
            CR_RESP       <= cr_next;
            CD_DATA       <= data_next ? snp_data : '0;
            CD_LAST       <= data_next;
        end else begin
            snoop_miss    <= 1'b0;
            invalid       <= 1'b0;
            response      <= 1'b0;
            response_data <= 1'b0;
            CR_RESP       <= 5'b00000;
            CD_DATA       <= '0;
            CD_LAST       <= 1'b0;
        end
    end
`else
    logic unused_snoop;

    assign snp_index     = '0;
    assign snp_state_we  = 1'b0;
    assign snp_wstate    = STATE_INVALID;
    assign snoop_miss    = 1'b0;
    assign invalid       = 1'b0;
    assign response      = 1'b0;
    assign response_data = 1'b0;
    assign CR_RESP       = 5'b00000;
    assign CD_DATA       = '0;
    assign CD_LAST       = 1'b0;
    assign unused_snoop  = ^{ac_enable, AC_ADDR, AC_SNOOP, AC_PROT, snp_tag, snp_data, snp_state};
`endif

    assign unused_inputs = ^{cpu_addr[OFFSET_W-1:0], RRESP[3:2], R_ID, R_LAST, B_ID};

endmodule

// File: tb/tb_ace_cache_datapath.sv
// Self-checking bench for ace_cache_datapath: directed steps followed by
// randomized cycles, all compared against a line-array reference model.
module tb_ace_cache_datapath;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        write_from_cpu, write_from_interconnect, mux_en;
    logic [2:0]  new_state, line_state;
    logic        cache_hit, cache_miss;
    logic        read_shared, make_unique, write_clean, read_resp_en, ac_enable;
    logic [31:0] AC_ADDR, RDATA;
    logic [3:0]  AC_SNOOP, RRESP, R_ID, B_ID;
    logic [2:0]  AC_PROT;
    logic        R_LAST;
    logic [1:0]  BRESP;
    logic        R_okay, B_okay, invalid, snoop_miss, response, response_data;
    logic [4:0]  CR_RESP;
    logic [31:0] CD_DATA;
    logic        CD_LAST;
    logic [31:0] AR_ADDR, AW_ADDR, W_DATA;
    logic [3:0]  AR_ID, AW_ID, AR_CACHE, AW_CACHE, AR_SNOOP;
    logic [2:0]  AR_SIZE, AW_SIZE, AR_PROT, AW_PROT, AW_SNOOP;
    logic [1:0]  AR_BURST, AW_BURST, AR_BAR, AW_BAR, AR_DOMAIN, AW_DOMAIN;
    logic [7:0]  AR_LEN, AW_LEN;
    logic        W_STRB, W_LAST;

    // Reference model: one entry per line.
    logic [25:0] m_tag   [16];
    logic [31:0] m_data  [16];
    logic [2:0]  m_state [16];
    logic        e_rok, e_bok, e_miss, e_inv, e_resp, e_rdat, e_cdl;
    logic [4:0]  e_cr;
    logic [31:0] e_cd;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ace_cache_datapath dut (
        .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .write_from_cpu(write_from_cpu),
        .write_from_interconnect(write_from_interconnect), .new_state(new_state),
        .mux_en(mux_en), .cache_hit(cache_hit), .cache_miss(cache_miss),
        .line_state(line_state), .read_shared(read_shared), .make_unique(make_unique),
        .write_clean(write_clean), .read_resp_en(read_resp_en), .ac_enable(ac_enable),
        .AC_ADDR(AC_ADDR), .AC_SNOOP(AC_SNOOP), .AC_PROT(AC_PROT), .RDATA(RDATA),
        .RRESP(RRESP), .R_ID(R_ID), .R_LAST(R_LAST), .BRESP(BRESP), .B_ID(B_ID),
        .R_okay(R_okay), .B_okay(B_okay), .invalid(invalid), .snoop_miss(snoop_miss),
        .response(response), .response_data(response_data), .CR_RESP(CR_RESP),
        .CD_DATA(CD_DATA), .CD_LAST(CD_LAST), .AR_ADDR(AR_ADDR), .AR_ID(AR_ID),
        .AR_SIZE(AR_SIZE), .AR_BURST(AR_BURST), .AR_LEN(AR_LEN), .AR_PROT(AR_PROT),
        .AR_CACHE(AR_CACHE), .AR_BAR(AR_BAR), .AR_DOMAIN(AR_DOMAIN), .AR_SNOOP(AR_SNOOP),
        .AW_ADDR(AW_ADDR), .AW_ID(AW_ID), .AW_SIZE(AW_SIZE), .AW_BURST(AW_BURST),
        .AW_LEN(AW_LEN), .AW_PROT(AW_PROT), .AW_CACHE(AW_CACHE), .AW_BAR(AW_BAR),
        .AW_DOMAIN(AW_DOMAIN), .AW_SNOOP(AW_SNOOP), .W_STRB(W_STRB), .W_LAST(W_LAST),
        .W_DATA(W_DATA)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("miscompare on %s", tag);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_tag[i]   = 26'd0;
            m_data[i]  = 32'd0;
            m_state[i] = 3'b011;
        end
        {e_rok, e_bok, e_miss, e_inv, e_resp, e_rdat, e_cdl} = 7'd0;
        e_cr = 5'd0;
        e_cd = 32'd0;
    endtask

    // One clock: check lookups and payloads, advance the model, check the
    // registered outputs after the edge. Called at posedge + 1.
    task automatic cycle();
        logic [3:0]  ci, si;
        logic        hit, s_hit, uniq, dirty, xfer, snp_upd;
        logic [2:0]  st, snp_st;
        #1;
        ci  = cpu_addr[5:2];
        hit = (m_tag[ci] == cpu_addr[31:6]) && (m_state[ci] != 3'b011);
        chk("cache_hit", {31'd0, cache_hit}, {31'd0, hit});
        chk("cache_miss", {31'd0, cache_miss}, {31'd0, !hit});
        chk("line_state", {29'd0, line_state}, {29'd0, m_state[ci]});
        chk("cpu_rdata", cpu_rdata, m_data[ci]);
        chk("W_DATA", W_DATA, m_data[ci]);
        chk("AR_ADDR", AR_ADDR, {cpu_addr[31:2], 2'b00});
        chk("AW_ADDR", AW_ADDR, {m_tag[ci], ci, 2'b00});
        chk("AR_SNOOP", {28'd0, AR_SNOOP},
            make_unique ? 32'hC : (read_shared ? 32'h1 : 32'h0));
        chk("AW_SNOOP", {29'd0, AW_SNOOP}, write_clean ? 32'h2 : 32'h0);

        if (!rst_n) begin
            model_reset();
        end else begin
            snp_upd = 1'b0;
            snp_st  = 3'b011;
            si      = AC_ADDR[5:2];
            {e_miss, e_inv, e_resp, e_rdat, e_cdl} = 5'd0;
            e_cr = 5'd0;
            e_cd = 32'd0;
`ifdef CACHE_DP_SNOOP_EN
            if (ac_enable) begin
                st    = m_state[si];
                s_hit = (m_tag[si] == AC_ADDR[31:6]) && (st != 3'b011);
                uniq  = (st == 3'b000) || (st == 3'b001);
                dirty = (st == 3'b001) || (st == 3'b010);
                e_resp = 1'b1;
                e_miss = !s_hit;
                if (s_hit) begin
                    if (AC_SNOOP == 4'b1001 || AC_SNOOP == 4'b1101) begin
                        xfer    = (AC_SNOOP == 4'b1001) && dirty;
                        e_inv   = 1'b1;
                        e_cr    = {uniq, 1'b0, xfer, 1'b0, xfer};
                        e_rdat  = xfer;
                        e_cdl   = xfer;
                        e_cd    = xfer ? m_data[si] : 32'd0;
                        snp_upd = 1'b1;
                        snp_st  = 3'b011;
                    end else begin
                        e_cr   = {uniq, 1'b1, st == 3'b001, 1'b0, 1'b1};
                        e_rdat = 1'b1;
                        e_cdl  = 1'b1;
                        e_cd   = m_data[si];
                        if (AC_SNOOP == 4'b0001) begin
                            snp_upd = 1'b1;
                            snp_st  = (st == 3'b010) ? 3'b010 : 3'b100;
                        end
                    end
                end
            end
`endif
            if (read_resp_en) e_rok = (RRESP[1:0] == 2'b00);
            e_bok = (BRESP == 2'b00);
            if (write_from_cpu || write_from_interconnect) begin
                m_tag[ci]  = cpu_addr[31:6];
                m_data[ci] = write_from_cpu ? cpu_wdata : RDATA;
            end
            if (mux_en) m_state[ci] = new_state;
            if (snp_upd) m_state[si] = snp_st;
        end

        @(posedge clk);
        #1;
        chk("R_okay", {31'd0, R_okay}, {31'd0, e_rok});
        chk("B_okay", {31'd0, B_okay}, {31'd0, e_bok});
        chk("snoop_miss", {31'd0, snoop_miss}, {31'd0, e_miss});
        chk("invalid", {31'd0, invalid}, {31'd0, e_inv});
        chk("response", {31'd0, response}, {31'd0, e_resp});
        chk("response_data", {31'd0, response_data}, {31'd0, e_rdat});
        chk("CR_RESP", {27'd0, CR_RESP}, {27'd0, e_cr});
        chk("CD_DATA", CD_DATA, e_cd);
        chk("CD_LAST", {31'd0, CD_LAST}, {31'd0, e_cdl});
    endtask

    function automatic logic [31:0] rand_addr();
        logic [25:0] t;
        case ($urandom_range(0, 2))
            0:       t = 26'h0;
            1:       t = 26'h1;
            default: t = 26'h40000;
        endcase
        return {t, 4'($urandom), 2'($urandom)};
    endfunction

    initial begin
        rst_n = 1'b0;
        cpu_addr = 32'd0; cpu_wdata = 32'd0; write_from_cpu = 1'b0;
        write_from_interconnect = 1'b0; new_state = 3'd0; mux_en = 1'b0;
        read_shared = 1'b0; make_unique = 1'b0; write_clean = 1'b0;
        read_resp_en = 1'b0; ac_enable = 1'b0; AC_ADDR = 32'd0; AC_SNOOP = 4'd0;
        AC_PROT = 3'd0; RDATA = 32'd0; RRESP = 4'd0; R_ID = 4'd0; R_LAST = 1'b0;
        BRESP = 2'd0; B_ID = 4'd0;
        @(posedge clk);
        #1;
        model_reset();
        cycle();

        // AXI constant fields.
        chk("AR_ID", {28'd0, AR_ID}, 32'h0);
        chk("AR_SIZE", {29'd0, AR_SIZE}, 32'h2);
        chk("AR_BURST", {30'd0, AR_BURST}, 32'h1);
        chk("AR_LEN", {24'd0, AR_LEN}, 32'h0);
        chk("AR_CACHE", {28'd0, AR_CACHE}, 32'h3);
        chk("AR_DOMAIN", {30'd0, AR_DOMAIN}, 32'h1);
        chk("AW_CACHE", {28'd0, AW_CACHE}, 32'h3);
        chk("AW_DOMAIN", {30'd0, AW_DOMAIN}, 32'h1);
        chk("W_STRB_LAST", {30'd0, W_STRB, W_LAST}, 32'h3);

        // Lookup after reset misses on an Invalid line.
        rst_n = 1'b1;
        cpu_addr = 32'h10;
        #1;
        chk("tp_miss", {31'd0, cache_miss}, 32'h1);
        chk("tp_state_inv", {29'd0, line_state}, 32'h3);
        cycle();

        read_shared = 1'b1;
        #1;
        chk("tp_ar_addr", AR_ADDR, 32'h10);
        chk("tp_ar_rs", {28'd0, AR_SNOOP}, 32'h1);
        cycle();
        make_unique = 1'b1;
        #1;
        chk("tp_ar_mu", {28'd0, AR_SNOOP}, 32'hC);
        cycle();
        read_shared = 1'b0; make_unique = 1'b0;

        // Interconnect fill with an OKAY read response.
        write_from_interconnect = 1'b1; RDATA = 32'hFEEDDEAD; RRESP = 4'b1000;
        read_resp_en = 1'b1;
        cycle();
        write_from_interconnect = 1'b0; read_resp_en = 1'b0;
        chk("tp_fill", cpu_rdata, 32'hFEEDDEAD);
        chk("tp_r_okay", {31'd0, R_okay}, 32'h1);
        cycle();

        // CPU write plus state update.
        write_from_cpu = 1'b1; cpu_wdata = 32'hDEADBEEF; mux_en = 1'b1; new_state = 3'b000;
        cycle();
        write_from_cpu = 1'b0; mux_en = 1'b0;
        #1;
        chk("tp_hit", {31'd0, cache_hit}, 32'h1);
        chk("tp_state_uc", {29'd0, line_state}, 32'h0);
        chk("tp_rdata", cpu_rdata, 32'hDEADBEEF);
        cycle();

        // Snoop miss on a different tag, then a ReadShared hit on UniqueDirty.
        ac_enable = 1'b1; AC_ADDR = 32'h01000010; AC_SNOOP = 4'b0001;
        cycle();
        ac_enable = 1'b0;
`ifdef CACHE_DP_SNOOP_EN
        chk("tp_snp_miss", {31'd0, snoop_miss}, 32'h1);
        chk("tp_snp_cr0", {27'd0, CR_RESP}, 32'h0);
`endif
        cycle();
        mux_en = 1'b1; new_state = 3'b001;
        cycle();
        mux_en = 1'b0;
        ac_enable = 1'b1; AC_ADDR = 32'h10;
        cycle();
        ac_enable = 1'b0;
`ifdef CACHE_DP_SNOOP_EN
        chk("tp_snp_cr", {27'd0, CR_RESP}, 32'h1D);
        chk("tp_snp_cd", CD_DATA, 32'hDEADBEEF);
        chk("tp_snp_last", {31'd0, CD_LAST}, 32'h1);
        #1;
        chk("tp_snp_sc", {29'd0, line_state}, 32'h4);
`endif
        cycle();

        // Randomized traffic over three tags so lines collide and hit.
        for (int n = 0; n < 400; n++) begin
            rst_n                   = ($urandom_range(0, 99) != 0);
            cpu_addr                = rand_addr();
            cpu_wdata               = $urandom;
            RDATA                   = $urandom;
            write_from_cpu          = ($urandom_range(0, 3) == 0);
            write_from_interconnect = ($urandom_range(0, 3) == 0);
            mux_en                  = ($urandom_range(0, 2) == 0);
            new_state               = 3'($urandom_range(0, 4));
            read_shared             = 1'($urandom);
            make_unique             = 1'($urandom);
            write_clean             = 1'($urandom);
            read_resp_en            = 1'($urandom);
            RRESP                   = 4'($urandom);
            BRESP                   = 2'($urandom);
            R_ID                    = 4'($urandom);
            B_ID                    = 4'($urandom);
            R_LAST                  = 1'($urandom);
            AC_PROT                 = 3'($urandom);
            ac_enable               = ($urandom_range(0, 2) == 0);
            AC_ADDR                 = ($urandom_range(0, 1) == 0) ? cpu_addr : rand_addr();
            case ($urandom_range(0, 4))
                0:       AC_SNOOP = 4'b0001;
                1:       AC_SNOOP = 4'b1001;
                2:       AC_SNOOP = 4'b1101;
                default: AC_SNOOP = 4'($urandom);
            endcase
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
